// File: rtl/axi_pkg.sv
// Shared AXI read-bridge definitions: response codes, burst encodings,
// FSM state type and the burst-legality helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Only 4-byte beats are served (one FIFO word per beat).
  localparam logic [2:0] SIZE_4B = 3'd2;

  typedef enum logic [1:0] {IDLE, RD, ERR} state_t;

  // FIXED and INCR behave identically on a FIFO-mapped port; anything else is an error.
  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == SIZE_4B);
  endfunction

endpackage

// File: rtl/axi_fifo_read_bridge_if.sv
// AXI4 read-address and read-data channel bundle for the FIFO read bridge.
// slave modport: the bridge; master modport: the host/interconnect side.
interface axi_fifo_read_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [1:0]            s_axi_arburst;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport slave (
    input  s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arsize, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport master (
    output s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arsize, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

endinterface

// File: rtl/axi_r_out_reg.sv
// R-channel output register. Holds a beat stable until the host accepts it;
// free tells the FSM a new beat may be loaded this cycle.
module axi_r_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            resp,
  input  logic                  last,
  input  logic                  rready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  free
);

  // Slot is free when empty or when the current beat is being accepted now.
  assign free = !rvalid || rready;

  // Capture a new beat on load; otherwise retire the held beat once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
      rlast  <= 1'b0;
    end else if (load) begin
      rvalid <= 1'b1;
      rdata  <= data;
      rresp  <= resp;
      rlast  <= last;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_fifo_read_bridge.sv
// AXI4 read-burst slave streaming words from a first-word-fall-through FIFO.
// Optional feature macro: AXI_RD_UNDERFLOW_TIMEOUT_EN -- aborts a burst that
// starves on an empty FIFO for TIMEOUT_CYCLES and finishes it with SLVERR beats.
module axi_fifo_read_bridge
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_PTR_W     = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_fifo_read_bridge_if.slave axi,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR_W:0]   fifo_count,
  output logic                  fifo_ren,
  output logic                  axi_error,
  output logic [31:0]           words_read
);

  state_t                state, state_nx;
  logic [7:0]            len;
  logic [8:0]            issued;
  logic                  arready;
  logic                  ar_take;
  logic                  bad_ar;
  logic                  beats_left;
  logic                  free;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [1:0]            load_resp;
  logic                  load_last;
  logic                  to_hit;
  logic                  unused_bits;

  // Address is meaningless on a FIFO port and occupancy is status only.
  assign unused_bits = ^{axi.s_axi_araddr, fifo_count};
  assign axi.s_axi_arready = arready;

`ifdef AXI_RD_UNDERFLOW_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Count starved cycles with an open slot and beats outstanding; any pop restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != RD || fifo_ren) begin
      to_cnt <= '0;
    end else if (fifo_empty && free && beats_left && to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES)) && beats_left;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-cycle controls: AR acceptance, FIFO pops, beat loads.
  always_comb begin
    state_nx   = state;
    arready    = 1'b0;
    ar_take    = 1'b0;
    bad_ar     = 1'b0;
    fifo_ren   = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    load_resp  = RESP_OKAY;
    load_last  = 1'b0;
    beats_left = (issued <= {1'b0, len});
    case (state)
      IDLE: begin
        arready = 1'b1;
        if (axi.s_axi_arvalid) begin
          ar_take  = 1'b1;
          bad_ar   = !burst_ok(axi.s_axi_arburst, axi.s_axi_arsize);
          state_nx = bad_ar ? ERR : RD;
        end
      end
      RD: begin
        if (!fifo_empty && free && beats_left) begin
          fifo_ren  = 1'b1;
          load      = 1'b1;
          load_data = fifo_rdata;
          load_last = (issued == {1'b0, len});
        end else if (to_hit) begin
          state_nx = ERR;
        end
        if (axi.s_axi_rvalid && axi.s_axi_rready && axi.s_axi_rlast) begin
          state_nx = IDLE;
        end
      end
      ERR: begin
        if (free && beats_left) begin
          load      = 1'b1;
          load_resp = RESP_SLVERR;
          load_last = (issued == {1'b0, len});
        end
        if (axi.s_axi_rvalid && axi.s_axi_rready && axi.s_axi_rlast) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst bookkeeping, sticky error flag and popped-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= '0;
      issued     <= '0;
      axi_error  <= 1'b0;
      words_read <= '0;
    end else begin
      if (ar_take) begin
        len       <= axi.s_axi_arlen;
        issued    <= '0;
        axi_error <= bad_ar;
      end else if (load) begin
        issued <= issued + 9'd1;
      end
      if (state == RD && to_hit && !fifo_ren) begin
        axi_error <= 1'b1;
      end
      if (fifo_ren) begin
        words_read <= words_read + 32'd1;
      end
    end
  end

  axi_r_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_r_out (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (load_data),
    .resp   (load_resp),
    .last   (load_last),
    .rready (axi.s_axi_rready),
    .rvalid (axi.s_axi_rvalid),
    .rdata  (axi.s_axi_rdata),
    .rresp  (axi.s_axi_rresp),
    .rlast  (axi.s_axi_rlast),
    .free   (free)
  );

endmodule

// File: tb/tb_axi_fifo_read_bridge.sv
// Self-checking bench for axi_fifo_read_bridge. The FIFO is modelled as a queue;
// expected beats come from the order words were pushed and the burst legality rules.
module tb_axi_fifo_read_bridge;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_fifo_read_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic [6:0]  fifo_count;
  logic        fifo_ren;
  logic        axi_error;
  logic [31:0] words_read;

  axi_fifo_read_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_PTR_W(6), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axi        (bus),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_ren   (fifo_ren),
    .axi_error  (axi_error),
    .words_read (words_read)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  logic [31:0] exp_stream[$];
  logic [31:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [31:0] exp_data[$];
  logic [1:0]  exp_resp[$];
  logic        exp_last[$];
  int          pops, hold_bad, rvalid_cycles, model_pops, rr_mode;
  bit          done_seen, timed_out, model_err, hold_pending;
  logic [31:0] wr_model;
  logic [31:0] h_data;
  logic [1:0]  h_resp;
  logic        h_last;

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_rdata = (q.size() != 0) ? q[0] : 32'h0;
    fifo_count = (q.size() > 127) ? 7'd127 : 7'(q.size());
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    exp_stream.push_back(w);
    drive_fifo();
  endtask

  task automatic flush_fifo();
    q.delete();
    exp_stream.delete();
    drive_fifo();
  endtask

  // One clock: observe at the falling edge, apply the pop and new inputs just after the rising edge.
  task automatic tick();
    bit pop_now, ar_acc;
    @(negedge clk);
    if (hold_pending) begin
      if (!(bus.s_axi_rvalid && bus.s_axi_rdata === h_data && bus.s_axi_rresp === h_resp &&
            bus.s_axi_rlast === h_last)) hold_bad++;
    end
    hold_pending = bus.s_axi_rvalid && !bus.s_axi_rready;
    h_data = bus.s_axi_rdata;
    h_resp = bus.s_axi_rresp;
    h_last = bus.s_axi_rlast;
    if (bus.s_axi_rvalid) rvalid_cycles++;
    if (bus.s_axi_rvalid && bus.s_axi_rready) begin
      got_data.push_back(bus.s_axi_rdata);
      got_resp.push_back(bus.s_axi_rresp);
      got_last.push_back(bus.s_axi_rlast);
      if (bus.s_axi_rlast) done_seen = 1'b1;
    end
    pop_now = fifo_ren;
    if (pop_now) pops++;
    ar_acc = bus.s_axi_arvalid && bus.s_axi_arready;
    @(posedge clk);
    #1;
    if (pop_now && q.size() != 0) void'(q.pop_front());
    if (ar_acc) bus.s_axi_arvalid = 1'b0;
    drive_fifo();
    case (rr_mode)
      0:       bus.s_axi_rready = 1'b1;
      1:       bus.s_axi_rready = ~bus.s_axi_rready;
      default: bus.s_axi_rready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_ar(input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
    bus.s_axi_araddr  = $urandom;
    bus.s_axi_arburst = burst;
    bus.s_axi_arlen   = len;
    bus.s_axi_arsize  = size;
    bus.s_axi_arvalid = 1'b1;
    got_data.delete();
    got_resp.delete();
    got_last.delete();
    pops = 0;
    hold_bad = 0;
    rvalid_cycles = 0;
    done_seen = 1'b0;
    hold_pending = 1'b0;
  endtask

  task automatic run_burst(input logic [1:0] burst, input int len, input logic [2:0] size,
                           input int extra_push, input int limit);
    int left;
    left = extra_push;
    start_ar(burst, 8'(len), size);
    for (int c = 0; c < limit && !done_seen; c++) begin
      if (left > 0 && $urandom_range(0, 2) == 0) begin
        push($urandom);
        left--;
      end
      tick();
    end
    timed_out = !done_seen;
  endtask

  // Reference: a legal burst returns the next len+1 pushed words as OKAY; otherwise zeros as SLVERR.
  function automatic void model_burst(input logic [1:0] burst, input int len, input logic [2:0] size);
    bit bad;
    bad = !((burst == BURST_FIXED || burst == BURST_INCR) && size == 3'd2);
    exp_data.delete();
    exp_resp.delete();
    exp_last.delete();
    for (int i = 0; i <= len; i++) begin
      exp_data.push_back((bad || exp_stream.size() == 0) ? 32'h0 : exp_stream.pop_front());
      exp_resp.push_back(bad ? 2'b10 : 2'b00);
      exp_last.push_back(i == len);
    end
    model_err  = bad;
    model_pops = bad ? 0 : len + 1;
    wr_model   = wr_model + 32'(model_pops);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.s_axi_arvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_model = 32'h0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.s_axi_arready !== 1'b1) begin failures++; $display("FAIL reset_arready got=%b exp=1", bus.s_axi_arready); end
    checks++; if (bus.s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.s_axi_rvalid); end
    checks++; if (bus.s_axi_rlast !== 1'b0 || bus.s_axi_rresp !== 2'b00 || bus.s_axi_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rbeat got=%b/%b/%h exp=0/00/0", bus.s_axi_rlast, bus.s_axi_rresp, bus.s_axi_rdata); end
    checks++; if (axi_error !== 1'b0 || words_read !== 32'h0 || fifo_ren !== 1'b0) begin
      failures++; $display("FAIL reset_status got=%b/%0d/%b exp=0/0/0", axi_error, words_read, fifo_ren); end
    apply_reset();
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
    rr_mode = 0;
    bus.s_axi_rready = 1'b1;
    run_burst(BURST_INCR, 3, 3'd2, 0, 50);
    model_burst(BURST_INCR, 3, 3'd2);
    checks++; if (got_data.size() != 4 || timed_out) begin failures++; $display("FAIL incr_beats got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_resp[i] !== exp_resp[i] || got_last[i] !== exp_last[i]) begin
        failures++; $display("FAIL incr_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_resp[i], got_last[i], exp_data[i], exp_resp[i], exp_last[i]); end
    end
    checks++; if (pops != 4) begin failures++; $display("FAIL incr_pops got=%0d exp=4", pops); end
    checks++; if (words_read !== wr_model) begin failures++; $display("FAIL incr_words_read got=%0d exp=%0d", words_read, wr_model); end
    checks++; if (bus.s_axi_arready !== 1'b1) begin failures++; $display("FAIL incr_arready_after got=%b exp=1", bus.s_axi_arready); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
    rr_mode = 1;
    bus.s_axi_rready = 1'b1;
    run_burst(BURST_INCR, 3, 3'd2, 0, 80);
    model_burst(BURST_INCR, 3, 3'd2);
    checks++; if (got_data.size() != 4 || timed_out) begin failures++; $display("FAIL bp_beats got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_resp[i] !== exp_resp[i] || got_last[i] !== exp_last[i]) begin
        failures++; $display("FAIL bp_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_resp[i], got_last[i], exp_data[i], exp_resp[i], exp_last[i]); end
    end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d changes exp=0", hold_bad); end
    checks++; if (pops != 4) begin failures++; $display("FAIL bp_pops got=%0d exp=4", pops); end
    rr_mode = 0;
    bus.s_axi_rready = 1'b1;
  endtask

  task automatic test_empty_stall();
    rr_mode = 0;
    start_ar(BURST_INCR, 8'd1, 3'd2);
    for (int c = 0; c < 20; c++) tick();
    checks++; if (rvalid_cycles != 0) begin failures++; $display("FAIL stall_rvalid got=%0d cycles exp=0", rvalid_cycles); end
    push(32'hA);
    push(32'hB);
    for (int c = 0; c < 40 && !done_seen; c++) tick();
    model_burst(BURST_INCR, 1, 3'd2);
    checks++; if (got_data.size() != 2 || !done_seen) begin failures++; $display("FAIL stall_beats got=%0d exp=2", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_resp[i] !== exp_resp[i] || got_last[i] !== exp_last[i]) begin
        failures++; $display("FAIL stall_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_resp[i], got_last[i], exp_data[i], exp_resp[i], exp_last[i]); end
    end
  endtask

  task automatic test_bad_burst();
    logic [1:0] bb[3];
    logic [2:0] bs[3];
    int         bl[3];
    bb = '{BURST_WRAP, 2'b11, BURST_INCR};
    bs = '{3'd2, 3'd2, 3'd1};
    bl = '{3, 0, 2};
    for (int i = 0; i < 3; i++) push($urandom);
    rr_mode = 2;
    for (int k = 0; k < 3; k++) begin
      run_burst(bb[k], bl[k], bs[k], 0, 60);
      model_burst(bb[k], bl[k], bs[k]);
      checks++; if (got_data.size() != exp_data.size() || timed_out) begin failures++; $display("FAIL bad%0d_beats got=%0d exp=%0d", k, got_data.size(), exp_data.size()); end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_resp[i] !== exp_resp[i] || got_last[i] !== exp_last[i]) begin
          failures++; $display("FAIL bad%0d_beat%0d got=%h/%b/%b exp=%h/%b/%b", k, i, got_data[i], got_resp[i], got_last[i], exp_data[i], exp_resp[i], exp_last[i]); end
      end
      checks++; if (pops != 0) begin failures++; $display("FAIL bad%0d_pops got=%0d exp=0", k, pops); end
      checks++; if (axi_error !== model_err) begin failures++; $display("FAIL bad%0d_axi_error got=%b exp=%b", k, axi_error, model_err); end
    end
    run_burst(BURST_FIXED, 0, 3'd2, 0, 40);
    model_burst(BURST_FIXED, 0, 3'd2);
    checks++; if (axi_error !== 1'b0) begin failures++; $display("FAIL bad_error_clear got=%b exp=0", axi_error); end
    checks++; if (got_data.size() != 1 || got_data[0] !== exp_data[0] || got_resp[0] !== 2'b00) begin
      failures++; $display("FAIL bad_recover_beat got=%0d beats exp=1 data=%h", got_data.size(), exp_data[0]); end
    checks++; if (words_read !== wr_model) begin failures++; $display("FAIL bad_words_read got=%0d exp=%0d", words_read, wr_model); end
    flush_fifo();
    rr_mode = 0;
  endtask

  task automatic test_random_bursts();
    for (int n = 0; n < 8; n++) begin
      logic [1:0] bt;
      int len, pre;
      bt  = $urandom_range(0, 1) ? BURST_INCR : BURST_FIXED;
      len = $urandom_range(0, 12);
      pre = $urandom_range(0, len + 1);
      for (int i = 0; i < pre; i++) push($urandom);
      rr_mode = 2;
      run_burst(bt, len, 3'd2, len + 1 - pre, 2000);
      model_burst(bt, len, 3'd2);
      checks++; if (got_data.size() != len + 1 || timed_out) begin failures++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", n, got_data.size(), len + 1); end
      for (int i = 0; i < got_data.size() && i <= len; i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_resp[i] !== exp_resp[i] || got_last[i] !== exp_last[i]) begin
          failures++; $display("FAIL rnd%0d_beat%0d got=%h/%b/%b exp=%h/%b/%b", n, i, got_data[i], got_resp[i], got_last[i], exp_data[i], exp_resp[i], exp_last[i]); end
      end
      checks++; if (hold_bad != 0 || pops != len + 1) begin failures++; $display("FAIL rnd%0d_hold_pops got=%0d/%0d exp=0/%0d", n, hold_bad, pops, len + 1); end
    end
    checks++; if (words_read !== wr_model) begin failures++; $display("FAIL rnd_words_read got=%0d exp=%0d", words_read, wr_model); end
    rr_mode = 0;
  endtask

  task automatic test_long_burst();
    int bad_beats;
    for (int i = 0; i < 256; i++) push($urandom);
    rr_mode = 2;
    run_burst(BURST_INCR, 255, 3'd2, 0, 2000);
    model_burst(BURST_INCR, 255, 3'd2);
    bad_beats = 0;
    for (int i = 0; i < got_data.size() && i < 256; i++) begin
      if (got_data[i] !== exp_data[i] || got_resp[i] !== exp_resp[i] || got_last[i] !== exp_last[i]) bad_beats++;
    end
    checks++; if (got_data.size() != 256 || timed_out) begin failures++; $display("FAIL long_beats got=%0d exp=256", got_data.size()); end
    checks++; if (bad_beats != 0) begin failures++; $display("FAIL long_beat_content got=%0d wrong beats exp=0", bad_beats); end
    checks++; if (pops != 256 || words_read !== wr_model) begin failures++; $display("FAIL long_pops got=%0d/%0d exp=256/%0d", pops, words_read, wr_model); end
    rr_mode = 0;
  endtask

  task automatic test_underflow();
    logic [31:0] w;
    w = $urandom;
    push(w);
    rr_mode = 0;
`ifdef AXI_RD_UNDERFLOW_TIMEOUT_EN
    run_burst(BURST_INCR, 3, 3'd2, 0, 200);
    checks++; if (got_data.size() != 4 || timed_out) begin failures++; $display("FAIL uf_beats got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_data[i] !== ((i == 0) ? w : 32'h0) || got_resp[i] !== ((i == 0) ? 2'b00 : 2'b10) || got_last[i] !== (i == 3)) begin
        failures++; $display("FAIL uf_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_data[i], got_resp[i], got_last[i], (i == 0) ? w : 32'h0, (i == 0) ? 2'b00 : 2'b10, i == 3); end
    end
    checks++; if (axi_error !== 1'b1 || pops != 1) begin failures++; $display("FAIL uf_status got=%b/%0d exp=1/1", axi_error, pops); end
    exp_stream.delete();
`else
    start_ar(BURST_INCR, 8'd3, 3'd2);
    for (int c = 0; c < 60; c++) tick();
    checks++; if (got_data.size() != 1 || done_seen) begin failures++; $display("FAIL uf_stall got=%0d beats exp=1 no last", got_data.size()); end
    checks++; if (got_data.size() > 0 && (got_data[0] !== w || got_resp[0] !== 2'b00)) begin
      failures++; $display("FAIL uf_first_beat got=%h/%b exp=%h/00", got_data[0], got_resp[0], w); end
    exp_stream.delete();
    apply_reset();
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) push($urandom);
    rr_mode = 0;
    start_ar(BURST_INCR, 8'd7, 3'd2);
    for (int c = 0; c < 30 && got_data.size() < 2; c++) tick();
    checks++; if (got_data.size() != 2) begin failures++; $display("FAIL rstmid_reach got=%0d beats exp=2", got_data.size()); end
    rst = 1'b1;
    #1;
    checks++; if (bus.s_axi_arready !== 1'b1 || bus.s_axi_rvalid !== 1'b0 || bus.s_axi_rlast !== 1'b0 ||
                  bus.s_axi_rresp !== 2'b00 || bus.s_axi_rdata !== 32'h0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%b/%b/%b/%h exp=1/0/0/00/0", bus.s_axi_arready, bus.s_axi_rvalid, bus.s_axi_rlast, bus.s_axi_rresp, bus.s_axi_rdata); end
    checks++; if (axi_error !== 1'b0 || words_read !== 32'h0) begin failures++; $display("FAIL rstmid_status got=%b/%0d exp=0/0", axi_error, words_read); end
    apply_reset();
    flush_fifo();
    w = $urandom;
    push(w);
    run_burst(BURST_INCR, 0, 3'd2, 0, 40);
    model_burst(BURST_INCR, 0, 3'd2);
    checks++; if (got_data.size() != 1 || got_data[0] !== w || got_last[0] !== 1'b1 || got_resp[0] !== 2'b00) begin
      failures++; $display("FAIL rstmid_single got=%0d beats exp=1 beat %h last=1", got_data.size(), w); end
    checks++; if (words_read !== wr_model) begin failures++; $display("FAIL rstmid_words_read got=%0d exp=%0d", words_read, wr_model); end
  endtask

  initial begin
    rst = 1'b1;
    wr_model = 32'h0;
    rr_mode = 0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arburst = BURST_INCR;
    bus.s_axi_arlen   = '0;
    bus.s_axi_arsize  = 3'd2;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;
    drive_fifo();
    test_reset();
    test_incr();
    test_backpressure();
    test_empty_stall();
    test_bad_burst();
    test_random_bursts();
    test_long_burst();
    test_underflow();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
